imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_boot_pkg.sv | 19 +
 rtl/word_pack.sv | 38 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared types and constants for the instruction-memory boot loader
package mips_boot_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  // Word count header length and instruction word size, in bytes
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_pack.sv
// rtl/word_pack.sv - big-endian byte-to-word assembly register with byte counter
module word_pack
  import mips_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  localparam int         WORD_W = BYTES_PER_WORD * 8;
  localparam logic [1:0] LAST   = 2'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        cnt_q;

  // Shift each accepted byte in at the low end so the first byte ends up most significant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[WORD_W-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Full fires on the shift that completes a word; the counter wraps to 0 on that same edge
  assign full_o = shift_i && (cnt_q == LAST);
  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed boot image into instruction memory
module imem_loader
  import mips_boot_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int                CW      = AW + 1;
  localparam int                LEN_W   = LEN_BYTES * 8;
  localparam logic [LEN_W-1:0] DEPTH_N = LEN_W'(DEPTH_WORDS);

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [CW-1:0]     word_cnt_q;
  logic              byte_ready_q;
  logic              imem_we_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              xfer;
  logic              can_start;
  logic              pack_full;
  logic [LEN_W-1:0]  len_d;
  logic [CW-1:0]     word_cnt_d;

  assign xfer       = byte_valid && byte_ready_q;
  assign can_start  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign len_d      = {len_q[LEN_W-1:8], byte_data};
  assign word_cnt_d = word_cnt_q + 1'b1;

  word_pack u_word_pack (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (can_start),
    .shift_i (xfer && (state_q == DATA)),
    .byte_i  (byte_data),
    .word_o  (imem_wdata),
    .full_o  (pack_full)
  );

  // Sequencer: every output is registered and set alongside the state it belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (can_start) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q[LEN_W-1:8] <= byte_data;
            state_q          <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_q <= len_d;
            if (len_d == '0) begin
              state_q      <= DONE;
              byte_ready_q <= 1'b0;
              cpu_reset_q  <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else if (len_d > DEPTH_N) begin
              state_q      <= ERR;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              err_q        <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (pack_full) begin
            state_q      <= WRITE;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b1;
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_d;
          if (LEN_W'(word_cnt_d) == len_q) begin
            state_q     <= DONE;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q      <= DATA;
            byte_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          cpu_reset_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = word_cnt_q[AW-1:0];
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  we_cnt = 0;

  imem_loader #(.DEPTH_WORDS(64), .AW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each write strobe pops the oldest expected write
  always @(negedge clk) begin
    if (imem_we) begin
      we_cnt++;
      chk("ready_in_write", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", 32'(imem_addr), 32'(e.addr));
        chk("wdata", imem_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send(w[i*8 +: 8]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_cpurst", 32'(cpu_reset), 32'd1);
    chk("start_ready", 32'(byte_ready), 32'd1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_done(input string tag, input int n_we);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(n_we));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #23;
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    // Two-word load
    we_cnt = 0;
    do_start();
    push_exp(6'd0, 32'h20080005);
    push_exp(6'd1, 32'hAC080004);
    send(8'h00); send(8'h02);
    send_word(32'h20080005, 1'b0);
    send_word(32'hAC080004, 1'b0);
    wait_end();
    check_done("two", 2);

    // Zero-length image
    we_cnt = 0;
    do_start();
    send(8'h00); send(8'h00);
    check_done("zero", 0);
    chk("zero_ready", 32'(byte_ready), 32'd0);

    // Oversize image
    we_cnt = 0;
    do_start();
    send(8'h00); send(8'h41);
    chk("big_err", 32'(err), 32'd1);
    chk("big_done", 32'(done), 32'd0);
    chk("big_cpurst", 32'(cpu_reset), 32'd1);
    chk("big_ready", 32'(byte_ready), 32'd0);
    chk("big_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("big_we_cnt", 32'(we_cnt), 32'd0);

    // Full-capacity boundary: 64 words accepted, last at address 63
    we_cnt = 0;
    do_start();
    send(8'h00); send(8'h40);
    chk("cap_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      push_exp(6'(i), w);
      send_word(w, 1'b0);
    end
    wait_end();
    check_done("cap", 64);

    // One word with byte_valid gaps
    we_cnt = 0;
    do_start();
    push_exp(6'd0, 32'hA1B2C3D4);
    send(8'h00); @(posedge clk); #1;
    send(8'h01); @(posedge clk); #1;
    send_word(32'hA1B2C3D4, 1'b1);
    wait_end();
    check_done("gap", 1);

    // Reset in the middle of a word
    we_cnt = 0;
    do_start();
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    byte_valid = 1'b1;
    byte_data  = 8'h44;
    repeat (2) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("abort_idle");
    chk("abort_we_cnt", 32'(we_cnt), 32'd0);
    do_start();
    push_exp(6'd0, 32'h12345678);
    send(8'h00); send(8'h01);
    send_word(32'h12345678, 1'b0);
    wait_end();
    check_done("reload", 1);

    // Start pulse while busy is ignored
    we_cnt = 0;
    do_start();
    push_exp(6'd0, 32'hDEADBEEF);
    push_exp(6'd1, 32'h0BADF00D);
    send(8'h00); send(8'h02);
    send(8'hDE); send(8'hAD);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_start_busy", 32'(busy), 32'd1);
    chk("mid_start_ready", 32'(byte_ready), 32'd1);
    send(8'hBE); send(8'hEF);
    send_word(32'h0BADF00D, 1'b0);
    wait_end();
    check_done("mid", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
